// File: rtl/servo_pkg.sv
// Shared types and defaults for the two-channel servo pulse generator.
package servo_pkg;

  localparam int WIDTH_BITS = 21;

  typedef logic [WIDTH_BITS-1:0] width_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT0 = 2'd1,
    SLOT1 = 2'd2
  } state_t;

  localparam int DEF_SLOT_TICKS = 1_000_000;
  localparam int DEF_MIN_W      = 100_000;
  localparam int DEF_MAX_W      = 200_000;

  function automatic width_t mid_width(input int mn, input int mx);
    return width_t'((mn + mx) / 2);
  endfunction

endpackage

// File: rtl/servo_slot_timer.sv
// Per-slot tick counter with terminal-count flag; held at zero when idle.
module servo_slot_timer
  import servo_pkg::*;
#(
  parameter int SLOT_TICKS = DEF_SLOT_TICKS
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   run,
  output width_t cnt_nxt,
  output logic   tc
);

  localparam width_t LAST = width_t'(SLOT_TICKS - 1);

  width_t cnt_q;
  width_t cnt_d;

  assign tc      = run && (cnt_q == LAST);
  assign cnt_nxt = cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + width_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Two-slot servo PWM frame generator with shadowed width registers.
// Define SERVO_CLAMP_EN to clamp written widths into [MIN_W, MAX_W].
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int SLOT_TICKS = DEF_SLOT_TICKS,
  parameter int MIN_W      = DEF_MIN_W,
  parameter int MAX_W      = DEF_MAX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        wr_valid,
  input  logic        wr_chan,
  input  logic [20:0] wr_width,
  output logic        wr_ready,
  output logic        pwm_out,
  output logic        chan_sel,
  output logic        frame_start
);

  localparam width_t MID_W  = mid_width(MIN_W, MAX_W);
  localparam width_t LAST_W = width_t'(SLOT_TICKS - 1);
`ifdef SERVO_CLAMP_EN
  localparam width_t LO_W   = width_t'(MIN_W);
  localparam width_t HI_W   = width_t'(MAX_W);
`endif

  state_t         state_q, state_d;
  width_t [1:0]   shadow_q, shadow_d;
  width_t [1:0]   active_q, active_d;
  logic           pwm_q, pwm_d;
  logic           sel_q, sel_d;
  logic           fs_q, fs_d;
  logic           rdy_q, rdy_d;

  logic           run;
  logic           tc;
  logic           load;
  width_t         cnt_nxt;
  width_t         wr_fit;

  assign run         = (state_q != IDLE);
  assign wr_ready    = rdy_q;
  assign pwm_out     = pwm_q;
  assign chan_sel    = sel_q;
  assign frame_start = fs_q;

  servo_slot_timer #(
    .SLOT_TICKS(SLOT_TICKS)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .cnt_nxt(cnt_nxt),
    .tc     (tc)
  );

  always_comb begin
`ifdef SERVO_CLAMP_EN
    if (wr_width < LO_W) begin
      wr_fit = LO_W;
    end else if (wr_width > HI_W) begin
      wr_fit = HI_W;
    end else begin
      wr_fit = wr_width;
    end
`else
    // Keep every pulse strictly inside its slot.
    wr_fit = (wr_width > LAST_W) ? LAST_W : wr_width;
`endif
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SLOT0;
          load    = 1'b1;
        end
      end
      SLOT0: begin
        if (tc) begin
          state_d = SLOT1;
        end
      end
      SLOT1: begin
        if (tc) begin
          if (enable) begin
            state_d = SLOT0;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    if (wr_valid && rdy_q) begin
      shadow_d[wr_chan] = wr_fit;
    end
    // Frame uses the shadow as it stood before this edge's write.
    active_d = load ? shadow_q : active_q;
  end

  always_comb begin
    fs_d  = load;
    sel_d = (state_d == SLOT1);
    rdy_d = 1'b1;
    pwm_d = 1'b0;
    unique case (state_d)
      SLOT0:   pwm_d = (cnt_nxt < active_d[0]);
      SLOT1:   pwm_d = (cnt_nxt < active_d[1]);
      default: pwm_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= {MID_W, MID_W};
      active_q <= {MID_W, MID_W};
      pwm_q    <= 1'b0;
      sel_q    <= 1'b0;
      fs_q     <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      sel_q    <= sel_d;
      fs_q     <= fs_d;
      rdy_q    <= rdy_d;
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: stimulus pushes per-frame widths,
// a monitor checks every frame's pulse shape against them.
module tb_servo_pwm_gen;

  localparam int SLOT_TICKS = 100;
  localparam int MIN_W      = 10;
  localparam int MAX_W      = 20;
  localparam int MID        = (MIN_W + MAX_W) / 2;
  localparam int NF         = 12;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        wr_valid;
  logic        wr_chan;
  logic [20:0] wr_width;
  logic        wr_ready;
  logic        pwm_out;
  logic        chan_sel;
  logic        frame_start;

  servo_pwm_gen #(
    .SLOT_TICKS(SLOT_TICKS),
    .MIN_W     (MIN_W),
    .MAX_W     (MAX_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .wr_valid   (wr_valid),
    .wr_chan    (wr_chan),
    .wr_width   (wr_width),
    .wr_ready   (wr_ready),
    .pwm_out    (pwm_out),
    .chan_sel   (chan_sel),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int w0;
    int w1;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   shadow_m[2];
  int   frames_pushed = 0;
  int   frames_seen   = 0;
  int   idle_err      = 0;
  bit   mon_en        = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Reference: what a written value becomes once stored.
  function automatic int store(input int w);
    int v;
    v = w & 32'h001F_FFFF;
`ifdef SERVO_CLAMP_EN
    if (v < MIN_W) return MIN_W;
    if (v > MAX_W) return MAX_W;
    return v;
`else
    if (v > SLOT_TICKS - 1) return SLOT_TICKS - 1;
    return v;
`endif
  endfunction

  task automatic push_frame();
    exp_t e;
    e.w0 = shadow_m[0];
    e.w1 = shadow_m[1];
    exp_q.push_back(e);
    frames_pushed++;
  endtask

  task automatic cycle(input bit v, input bit c, input int w, input bit en);
    @(negedge clk);
    wr_valid = v;
    wr_chan  = c;
    wr_width = w[20:0];
    enable   = en;
    @(posedge clk);
    if (v) shadow_m[c] = store(w);
  endtask

  // Monitor: one frame = 2 * SLOT_TICKS cycles after frame_start.
  bit in_frame = 1'b0;
  int s;
  int ew[2];
  int hi[2];
  int err[2];

  always @(posedge clk) begin
    #1;
    if (!mon_en) begin
      in_frame = 1'b0;
    end else begin
      if (frame_start) begin
        if (in_frame) chk("frame_len", s, 2 * SLOT_TICKS - 1);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_pop: got unexpected frame_start, expected none");
          ew[0] = 0;
          ew[1] = 0;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          ew[0] = e.w0;
          ew[1] = e.w1;
        end
        frames_seen++;
        in_frame = 1'b1;
        s = 0;
        for (int i = 0; i < 2; i++) begin
          hi[i]  = 0;
          err[i] = 0;
        end
      end else if (in_frame) begin
        s++;
        if (s == 2 * SLOT_TICKS) in_frame = 1'b0;
      end
      if (in_frame) begin
        int sl;
        int k;
        sl = (s >= SLOT_TICKS) ? 1 : 0;
        k  = s - sl * SLOT_TICKS;
        if (pwm_out === 1'b1) hi[sl]++;
        if (chan_sel !== sl[0] || pwm_out !== (k < ew[sl])) err[sl]++;
        if (k == SLOT_TICKS - 1) begin
          n_tests++;
          if (err[sl] != 0) begin
            n_fail++;
            $display("FAIL frame%0d_slot%0d_pulse: got %0d high cycles (%0d bad), expected %0d",
                     frames_seen, sl, hi[sl], err[sl], ew[sl]);
          end
        end
      end else begin
        if (pwm_out !== 1'b0 || chan_sel !== 1'b0 || frame_start !== 1'b0)
          idle_err++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_chan  = 1'b0;
    wr_width = '0;
    shadow_m[0] = MID;
    shadow_m[1] = MID;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_chan_sel", int'(chan_sel), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_wr_ready", int'(wr_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wr_ready_up", int'(wr_ready), 1);
    @(negedge clk);
    mon_en = 1'b1;

    for (int f = 0; f < NF; f++) begin
      push_frame();
      for (int j = 0; j < 2 * SLOT_TICKS; j++) begin
        bit v;
        bit c;
        int w;
        bit en;
        v  = 1'b0;
        c  = 1'b0;
        w  = 0;
        en = !(f == NF - 1 && j >= 30);
        case (f)
          1: begin
            if (j == 10)  begin v = 1; c = 0; w = 30; end
            if (j == 40)  begin v = 1; c = 0; w = 12; end
            if (j == 120) begin v = 1; c = 1; w = 18; end
          end
          2: begin
            if (j == 50)  begin v = 1; c = 0; w = 5;  end
            if (j == 150) begin v = 1; c = 1; w = 50; end
          end
          3: begin
            if (j == 5)  begin v = 1; c = 0; w = 0;      end
            if (j == 60) begin v = 1; c = 1; w = 200000; end
          end
          4: begin
            if (j == 0)   begin v = 1; c = 0; w = 17; end
            if (j == 100) begin v = 1; c = 1; w = 11; end
          end
          default: begin
            if (f >= 5 && $urandom_range(0, 19) == 0) begin
              v = 1;
              c = 1'($urandom_range(0, 1));
              if ($urandom_range(0, 3) == 0) w = int'($urandom_range(0, 2097151));
              else w = int'($urandom_range(0, 120));
            end
          end
        endcase
        cycle(v, c, w, en);
      end
    end

    repeat (250) cycle(1'b0, 1'b0, 0, 1'b0);
    chk("idle_outputs", idle_err, 0);

    push_frame();
    for (int j = 0; j < 5; j++) cycle(j == 2, 1'b0, 13, 1'b1);
    #1;
    chk("pre_reset_pwm", int'(pwm_out), 1);
    @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_pwm_out", int'(pwm_out), 0);
    chk("mid_rst_chan_sel", int'(chan_sel), 0);
    chk("mid_rst_frame_start", int'(frame_start), 0);
    chk("mid_rst_wr_ready", int'(wr_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    enable   = 1'b0;
    wr_valid = 1'b0;
    shadow_m[0] = MID;
    shadow_m[1] = MID;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_wr_ready", int'(wr_ready), 1);
    @(negedge clk);
    mon_en = 1'b1;

    push_frame();
    for (int j = 0; j < 2 * SLOT_TICKS; j++) cycle(1'b0, 1'b0, 0, j < 30);
    repeat (20) cycle(1'b0, 1'b0, 0, 1'b0);

    chk("exp_queue_left", exp_q.size(), 0);
    chk("frames_seen", frames_seen, frames_pushed);
    chk("final_idle", idle_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
